// File: rtl/cordic_iter_core_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : cordic_iter_core_if                                     |
// | Description : Sample-in / result-out handshake bundle for the folded  |
// |               CORDIC engine. slave = core side, master = client side. |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
interface cordic_iter_core_if #(
  parameter int BITS = 16
);
  logic              s_valid_i;
  logic              s_ready_o;
  logic              s_mode_i;
  logic [BITS-1:0]   s_x_i;
  logic [BITS-1:0]   s_y_i;
  logic [BITS-1:0]   s_z_i;
  logic              m_valid_o;
  logic              m_ready_i;
  logic              m_mode_o;
  logic [BITS+1:0]   m_x_o;
  logic [BITS+1:0]   m_y_o;
  logic [BITS-1:0]   m_z_o;

  modport slave (
    input  s_valid_i, s_mode_i, s_x_i, s_y_i, s_z_i, m_ready_i,
    output s_ready_o, m_valid_o, m_mode_o, m_x_o, m_y_o, m_z_o
  );

  modport master (
    output s_valid_i, s_mode_i, s_x_i, s_y_i, s_z_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_mode_o, m_x_o, m_y_o, m_z_o
  );
endinterface
`default_nettype wire

// File: rtl/cordic_iter_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : cordic_iter_core                                        |
// | Description : Folded CORDIC engine, rotation (sin/cos) and vectoring  |
// |               (magnitude/atan) modes, one shift-add stage reused for  |
// |               ITERS cycles per sample.                                |
// |               Optional macro CORDIC_GAIN_COMP_EN adds a SCALE state   |
// |               that removes the CORDIC gain K from x/y.                |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module cordic_iter_core #(
  parameter int BITS  = 16,
  parameter int ITERS = 16,
  parameter int GUARD = 2
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  cordic_iter_core_if.slave  bus
);

  localparam int  W  = BITS + 2 + GUARD;   // internal x/y width
  localparam int  ZW = BITS + GUARD;       // internal angle width
  localparam int  CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam real c_pi_real = 3.14159265358979323846;
  localparam logic [ZW-1:0] c_half = {1'b1, {(ZW-1){1'b0}}};  // pi in binary angle

  localparam logic [1:0] c_idle  = 2'd0;
  localparam logic [1:0] c_iter  = 2'd1;
`ifdef CORDIC_GAIN_COMP_EN
  localparam logic [1:0] c_scale = 2'd2;
`endif
  localparam logic [1:0] c_done  = 2'd3;

  if (ITERS < 1 || ITERS > BITS + GUARD) begin : g_bad_iters
    $error("cordic_iter_core: ITERS must lie in 1..BITS+GUARD");
  end

  // atan(2^-i) scaled so that pi maps to 2^(ZW-1)
  function automatic logic [ZW-1:0] f_atan(input int i);
    real v;
    v = $atan(1.0 / (2.0 ** i)) / c_pi_real * (2.0 ** (ZW - 1));
    return ZW'($rtoi(v + 0.5));
  endfunction

  logic [ZW-1:0] w_rom [ITERS];
  for (genvar gi = 0; gi < ITERS; gi++) begin : g_rom
    localparam logic [ZW-1:0] c_atan = f_atan(gi);
    assign w_rom[gi] = c_atan;
  end

  logic [1:0]             r_state;
  logic [CW-1:0]          r_iter;
  logic signed [W-1:0]    r_x, r_y;
  logic signed [ZW-1:0]   r_z;
  logic                   r_mode;
  logic [BITS+1:0]        r_mx, r_my;
  logic [BITS-1:0]        r_mz;

  // Input alignment: sign-extend to the internal width, then append guard bits
  logic signed [W-1:0]    w_in_x, w_in_y;
  logic signed [ZW-1:0]   w_in_z;
  assign w_in_x = W'($signed(bus.s_x_i)) <<< GUARD;
  assign w_in_y = W'($signed(bus.s_y_i)) <<< GUARD;
  assign w_in_z = ZW'($signed(bus.s_z_i)) <<< GUARD;

  // Quadrant pre-rotation by pi so the micro-rotations only cover +/- pi/2
  logic signed [W-1:0]    w_ld_x, w_ld_y;
  logic signed [ZW-1:0]   w_ld_z;
  always_comb begin
    w_ld_x = w_in_x;
    w_ld_y = w_in_y;
    w_ld_z = w_in_z;
    if (bus.s_mode_i) begin
      w_ld_z = '0;
      if (w_in_x[W-1]) begin
        w_ld_x = -w_in_x;
        w_ld_y = -w_in_y;
        w_ld_z = c_half;
      end
    end else if (w_in_z[ZW-1] != w_in_z[ZW-2]) begin
      w_ld_x = -w_in_x;
      w_ld_y = -w_in_y;
      w_ld_z = w_in_z ^ c_half;  // + pi, modulo full circle
    end
  end

  // One micro-rotation of the shared shift-add stage
  logic                   w_d_pos;
  logic signed [W-1:0]    w_xs, w_ys, w_x_nx, w_y_nx;
  logic signed [ZW-1:0]   w_atan, w_z_nx;
  assign w_d_pos = r_mode ? r_y[W-1] : ~r_z[ZW-1];
  assign w_xs    = r_x >>> r_iter;
  assign w_ys    = r_y >>> r_iter;
  assign w_atan  = w_rom[r_iter];
  assign w_x_nx  = w_d_pos ? (r_x - w_ys)   : (r_x + w_ys);
  assign w_y_nx  = w_d_pos ? (r_y + w_xs)   : (r_y - w_xs);
  assign w_z_nx  = w_d_pos ? (r_z - w_atan) : (r_z + w_atan);

  // Values that feed output rounding on entry to DONE
  logic signed [W-1:0]    w_x_fin, w_y_fin;
  logic signed [ZW-1:0]   w_z_fin;
`ifdef CORDIC_GAIN_COMP_EN
  function automatic real f_gain();
    real k;
    k = 1.0;
    for (int i = 0; i < ITERS; i++) k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
    return k;
  endfunction

  localparam logic signed [BITS+1:0] c_kinv =
    (BITS+2)'($rtoi((2.0 ** (BITS + 1)) / f_gain() + 0.5));

  logic signed [W+BITS+1:0] w_px, w_py;
  assign w_px    = r_x * c_kinv;
  assign w_py    = r_y * c_kinv;
  assign w_x_fin = W'(w_px >>> (BITS + 1));
  assign w_y_fin = W'(w_py >>> (BITS + 1));
  assign w_z_fin = r_z;
`else
  assign w_x_fin = w_x_nx;
  assign w_y_fin = w_y_nx;
  assign w_z_fin = w_z_nx;
`endif

  // Round-half-up removal of the guard bits
  logic signed [BITS+1:0] w_x_rnd, w_y_rnd;
  logic signed [BITS-1:0] w_z_rnd;
  if (GUARD > 0) begin : g_rnd_guard
    localparam logic signed [W-1:0]  c_rnd_xy = W'(1) <<< (GUARD - 1);
    localparam logic signed [ZW-1:0] c_rnd_z  = ZW'(1) <<< (GUARD - 1);
    assign w_x_rnd = (BITS+2)'((w_x_fin + c_rnd_xy) >>> GUARD);
    assign w_y_rnd = (BITS+2)'((w_y_fin + c_rnd_xy) >>> GUARD);
    assign w_z_rnd = BITS'((w_z_fin + c_rnd_z) >>> GUARD);
  end else begin : g_rnd_none
    assign w_x_rnd = (BITS+2)'(w_x_fin);
    assign w_y_rnd = (BITS+2)'(w_y_fin);
    assign w_z_rnd = BITS'(w_z_fin);
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= c_idle;
      r_iter  <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
      r_mode  <= 1'b0;
      r_mx    <= '0;
      r_my    <= '0;
      r_mz    <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (bus.s_valid_i) begin
            r_x     <= w_ld_x;
            r_y     <= w_ld_y;
            r_z     <= w_ld_z;
            r_mode  <= bus.s_mode_i;
            r_iter  <= '0;
            r_state <= c_iter;
          end
        end
        c_iter: begin
          r_x <= w_x_nx;
          r_y <= w_y_nx;
          r_z <= w_z_nx;
          if (r_iter == CW'(ITERS - 1)) begin
`ifdef CORDIC_GAIN_COMP_EN
            r_state <= c_scale;
`else
            r_mx    <= w_x_rnd;
            r_my    <= w_y_rnd;
            r_mz    <= w_z_rnd;
            r_state <= c_done;
`endif
          end else begin
            r_iter <= r_iter + 1'b1;
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        c_scale: begin
          r_mx    <= w_x_rnd;
          r_my    <= w_y_rnd;
          r_mz    <= w_z_rnd;
          r_state <= c_done;
        end
`endif
        c_done: begin
          if (bus.m_ready_i) r_state <= c_idle;
        end
        default: r_state <= c_idle;
      endcase
    end
  end

  assign bus.s_ready_o = (r_state == c_idle);
  assign bus.m_valid_o = (r_state == c_done);
  assign bus.m_mode_o  = r_mode;
  assign bus.m_x_o     = r_mx;
  assign bus.m_y_o     = r_my;
  assign bus.m_z_o     = r_mz;

endmodule
`default_nettype wire

// File: doc/cordic_iter_core.md
Name: cordic_iter_core

Overview:
- Folded (iterative) CORDIC engine supporting both rotation mode (sin/cos generation) and vectoring mode (magnitude/atan).
- One shared shift-add datapath is reused for ITERS cycles per sample, trading throughput for area.
- Valid/ready handshakes on input and output.
- Sits beside the UART command decoder as the general-purpose trig/magnitude unit for UART_CORDIC.

Parameters:
- BITS, 16: width of input x/y/z and output z; output x/y are BITS+2.
- ITERS, 16: micro-rotations per sample; legal range 1..BITS+GUARD (elaboration $error otherwise).
- GUARD, 2: extra fractional LSBs carried internally; 0 is legal.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- s_valid_i  in  1  input sample valid
- s_ready_o  out  1  core can accept a sample
- s_mode_i  in  1  0 = rotation, 1 = vectoring
- s_x_i  in  BITS  signed x
- s_y_i  in  BITS  signed y
- s_z_i  in  BITS  signed angle (binary angle: −2^(BITS−1) = −π, full circle = 2^BITS)
- m_valid_o  out  1  result valid
- m_ready_i  in  1  downstream accepts result
- m_mode_o  out  1  mode of the returned sample
- m_x_o  out  BITS+2  signed x result
- m_y_o  out  BITS+2  signed y result
- m_z_o  out  BITS  signed angle result (residual angle in rotation mode, accumulated angle in vectoring mode)

Behaviour:
- Reset: asynchronous on rst_ni low. Outputs/registers at reset: state=IDLE, s_ready_o=1, m_valid_o=0, m_mode_o=0, m_x_o=m_y_o=m_z_o=0, iteration counter=0.
- Internal widths: x/y are W=BITS+2+GUARD signed (inputs sign-extended, then shifted left by GUARD); z is BITS+GUARD.
- Atan ROM: entry i = round(atan(2^−i)/π · 2^(BITS+GUARD−1)), computed at elaboration via real functions.
- FSM states: IDLE, ITER, (SCALE with GAIN_COMP_EN), DONE. s_ready_o = (state==IDLE).
- IDLE, on s_valid_i&&s_ready_o: load registers with quadrant pre-rotation, counter=0, go to ITER.
  - Rotation: if z[BITS−1]!=z[BITS−2] (|z|>π/2), load x=−x, y=−y, z=z+2^(BITS−1) (modular wrap).
  - Vectoring: if x<0, load x=−x, y=−y, z=2^(BITS−1) (π), else z=0 (s_z_i ignored).
  - Negation of −2^(BITS−1) does not overflow, since W>BITS.
- ITER, step i = counter:
  - d = +1 if (rotation: z>=0) or (vectoring: y<0), else −1.
  - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atan[i].
  - Arithmetic shifts; z wraps modulo 2^(BITS+GUARD).
  - At counter==ITERS−1, go to DONE (or SCALE); otherwise counter+1.
- DONE: m_valid_o=1, outputs held stable until m_ready_i. On m_valid_o&&m_ready_i, go to IDLE with m_valid_o=0 on the next edge.
- Output rounding: x/y = (internal + 2^(GUARD−1)) >>> GUARD (no add when GUARD=0); z = same rounding to BITS.
- Latency: accept edge k → m_valid_o high after edge k+ITERS (k+ITERS+1 with GAIN_COMP_EN). Throughput: one sample per ITERS+2 cycles minimum.
- Gain: without compensation, x/y carry CORDIC gain K≈1.6468; the 2 growth bits absorb K·√2.
- s_valid_i is ignored outside IDLE. Inputs are sampled only on the accept edge; changing them afterwards has no effect.
- m_ready_i high while m_valid_o is low has no effect.
- Reset mid-operation: in-flight sample is discarded; no m_valid_o pulse after release.

Optional Feature:
- Macro CORDIC_GAIN_COMP_EN.
- Defined: extra SCALE state after ITER multiplies x and y by KINV = round(2^(BITS+1)/K), then arithmetic-shifts right by BITS+1 before output rounding. Outputs are gain-free; latency +1.
- Undefined: no SCALE state, no multiplier; outputs include gain K.

Test Plan:
- Rotation, BITS=16/ITERS=16/GUARD=2, x=19898, y=0, z=0x2000 (π/4) → m_x_o=m_y_o=23170±4, m_z_o within ±2 of 0, m_valid_o high exactly 16 cycles after accept.
- Rotation wrap: x=19898, y=0, z=0x8000 (−π) → m_x_o=−32768±4, m_y_o=0±4 (pre-rotation path).
- Vectoring: x=10000, y=10000 → m_x_o=23289±4 (14142±3 with CORDIC_GAIN_COMP_EN), m_y_o=0±4, m_z_o=0x2000±2.
- Vectoring left half-plane: x=−10000, y=0 → m_z_o=0x8000±2 (as signed −32768, modulo wrap accepted), m_x_o=16468±4.
- Backpressure: hold m_ready_i low 10 cycles after m_valid_o → outputs stable, s_ready_o=0, second s_valid_i ignored. Release → one handshake, then s_ready_o=1 next cycle.
- Reset: pull rst_ni low at iteration 5 → m_valid_o=0, s_ready_o=1 immediately (asynchronous), all outputs 0. No result emitted; next sample processes correctly.
